// File: rtl/stream_framer.sv
// stream_framer: buffers a 32-bit valid/ready word stream in a FIFO and emits
// frames of HEAD {FRAME_HEAD, seq}, LEN {16'h0, n}, n payload words, and an XOR
// TAIL with m_last. A frame launches on a full frame, a timeout or a flush.
// Ports:
//   clk, reset        clock, async active-high reset
//   flush             one-cycle request to frame whatever is buffered
//   s_valid/s_ready/s_data  input word stream (s_ready = !fifo_full)
//   m_valid/m_ready/m_data/m_last  output frame stream (m_last on TAIL)
//   frame_cnt         frames completed, wraps
//   fifo_level        current FIFO occupancy
module stream_framer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FRAME_WORDS = 256,
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned TIMEOUT     = 1024,
  parameter logic [15:0] FRAME_HEAD  = 16'hA55A
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_last,
  output logic [31:0]                  frame_cnt,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned NW = 16;

  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_LEN, S_PAYLOAD, S_TAIL} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q, rd_next;
  logic [LW-1:0]         level_d;
  logic                  s_ready_d;
  logic                  m_valid_d, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_d;
  logic [NW-1:0]         n_q, n_d, pay_cnt_q, pay_cnt_d, seq_q, seq_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic [31:0]           frame_cnt_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  tfire_q, tfire_d;
  logic                  wr_en, rd_en, out_hs, is_idle, start;

  assign wr_en   = s_valid && s_ready;
  assign out_hs  = m_valid && m_ready;
  assign rd_en   = (state_q == S_PAYLOAD) && out_hs;
  assign rd_next = rd_ptr_q + AW'(1);
  assign is_idle = (state_q == S_IDLE);
  assign start   = is_idle && ((32'(fifo_level) >= FRAME_WORDS) || tfire_q ||
                               (flush_pend_q && (fifo_level != '0)));

  // FIFO storage; contents are discarded by resetting the pointers only
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= s_data;
  end

  // Next-state, output words and frame bookkeeping
  always_comb begin
    state_d     = state_q;
    m_valid_d   = m_valid;
    m_data_d    = m_data;
    m_last_d    = m_last;
    n_d         = n_q;
    pay_cnt_d   = pay_cnt_q;
    csum_d      = csum_q;
    seq_d       = seq_q;
    frame_cnt_d = frame_cnt;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_HEAD;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          m_data_d  = DATA_WIDTH'({FRAME_HEAD, seq_q});
          csum_d    = '0;
          if (32'(fifo_level) >= FRAME_WORDS) n_d = NW'(FRAME_WORDS);
          else                                n_d = NW'(fifo_level);
        end
      end
      S_HEAD: begin
        if (out_hs) begin
          state_d  = S_LEN;
          m_data_d = DATA_WIDTH'({16'h0, n_q});
        end
      end
      S_LEN: begin
        // Present the head of the FIFO without popping; pops follow handshakes
        if (out_hs) begin
          state_d   = S_PAYLOAD;
          m_data_d  = mem[rd_ptr_q];
          pay_cnt_d = NW'(1);
        end
      end
      S_PAYLOAD: begin
        if (out_hs) begin
          csum_d = csum_q ^ m_data;
          if (pay_cnt_q == n_q) begin
            state_d  = S_TAIL;
            m_data_d = csum_q ^ m_data;
            m_last_d = 1'b1;
          end else begin
            m_data_d  = mem[rd_next];
            pay_cnt_d = pay_cnt_q + NW'(1);
          end
        end
      end
      S_TAIL: begin
        if (out_hs) begin
          state_d     = S_IDLE;
          m_valid_d   = 1'b0;
          m_last_d    = 1'b0;
          m_data_d    = '0;
          seq_d       = seq_q + NW'(1);
          frame_cnt_d = frame_cnt + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO level, flush request and idle timeout
  always_comb begin
    level_d = fifo_level;
    if (wr_en && !rd_en)      level_d = fifo_level + LW'(1);
    else if (rd_en && !wr_en) level_d = fifo_level - LW'(1);
    s_ready_d = (level_d != LW'(FIFO_DEPTH));

    flush_pend_d = flush_pend_q;
    if (flush)                                  flush_pend_d = 1'b1;
    else if (start)                             flush_pend_d = 1'b0;
    else if (is_idle && (fifo_level == '0))     flush_pend_d = 1'b0;

    // Registered fire adds one cycle: HEAD lands TIMEOUT+1 after the first count
    tcnt_d  = '0;
    tfire_d = 1'b0;
    if (is_idle && (fifo_level != '0) && !start) begin
      tcnt_d  = (tcnt_q == TW'(TIMEOUT - 1)) ? tcnt_q : tcnt_q + TW'(1);
      tfire_d = (tcnt_q == TW'(TIMEOUT - 1));
    end
  end

  // State register and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      s_ready      <= 1'b1;
      fifo_level   <= '0;
      frame_cnt    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      n_q          <= '0;
      pay_cnt_q    <= '0;
      csum_q       <= '0;
      seq_q        <= '0;
      flush_pend_q <= 1'b0;
      tcnt_q       <= '0;
      tfire_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_valid      <= m_valid_d;
      m_data       <= m_data_d;
      m_last       <= m_last_d;
      s_ready      <= s_ready_d;
      fifo_level   <= level_d;
      frame_cnt    <= frame_cnt_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_next;
      n_q          <= n_d;
      pay_cnt_q    <= pay_cnt_d;
      csum_q       <= csum_d;
      seq_q        <= seq_d;
      flush_pend_q <= flush_pend_d;
      tcnt_q       <= tcnt_d;
      tfire_q      <= tfire_d;
    end
  end

endmodule

// File: tb/tb_stream_framer.sv
// Testbench for stream_framer: directed scenarios plus random traffic, checked
// against a frame parser and a queue of accepted words.
module tb_stream_framer;

  localparam int unsigned FRAME_WORDS = 256;
  localparam int unsigned FIFO_DEPTH  = 512;
  localparam int unsigned TIMEOUT     = 1024;

  logic        clk, reset, flush;
  logic        s_valid, s_ready, m_valid, m_ready, m_last;
  logic [31:0] s_data, m_data, frame_cnt;
  logic [9:0]  fifo_level;

  stream_framer #(
    .DATA_WIDTH (32),
    .FRAME_WORDS(FRAME_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT),
    .FRAME_HEAD (16'hA55A)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .frame_cnt (frame_cnt),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  // Reference model state
  logic [31:0] sb [$];
  int          beat = 0, cur_n = 0, pay_left = 0;
  logic [15:0] exp_seq = 16'h0;
  logic [31:0] acc = 32'h0;
  int          frames_seen = 0;
  int          head_cyc = 0, last_wr_cyc = 0, frame_cycles = 0;
  logic [31:0] last_head = 32'h0, last_len = 32'h0, last_tail = 32'h0;
  logic        stalled = 1'b0, hold_last = 1'b0, s_hs = 1'b0;
  logic [31:0] hold_data = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    beat = 0; pay_left = 0; exp_seq = 16'h0; frames_seen = 0; stalled = 1'b0;
  endtask

  // Parse one accepted output beat against the expected frame layout
  task automatic frame_beat();
    logic [31:0] exp;
    if (beat == 0) begin
      check("head", m_data, {16'hA55A, exp_seq});
      check("head_last", 32'(m_last), 32'd0);
      last_head = m_data; head_cyc = cyc; acc = 32'h0; beat = 1;
    end else if (beat == 1) begin
      check("len_hi", 32'(m_data[31:16]), 32'd0);
      cur_n = int'(m_data[15:0]);
      check("len_range", 32'(cur_n >= 1 && cur_n <= int'(FRAME_WORDS)), 32'd1);
      check("len_avail", 32'(sb.size() >= cur_n), 32'd1);
      check("len_last", 32'(m_last), 32'd0);
      last_len = m_data; pay_left = cur_n; beat = 2;
    end else if (pay_left > 0) begin
      check("payload_avail", 32'(sb.size() > 0), 32'd1);
      exp = (sb.size() > 0) ? sb.pop_front() : m_data;
      check("payload", m_data, exp);
      check("payload_last", 32'(m_last), 32'd0);
      acc ^= exp;
      pay_left--;
    end else begin
      check("tail", m_data, acc);
      check("tail_last", 32'(m_last), 32'd1);
      last_tail = m_data; frame_cycles = cyc - head_cyc + 1;
      exp_seq++; frames_seen++; beat = 0;
    end
  endtask

  // Called at a falling edge with inputs settled: score this cycle, advance one
  task automatic tick();
    if (stalled) begin
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_data", m_data, hold_data);
      check("stall_last", 32'(m_last), 32'(hold_last));
    end
    check("s_ready_full", 32'(s_ready), 32'(fifo_level != 10'(FIFO_DEPTH)));
    check("level", 32'(fifo_level), 32'(sb.size()));
    s_hs = s_valid && s_ready;
    if (m_valid && m_ready) frame_beat();
    if (s_hs) begin
      sb.push_back(s_data);
      last_wr_cyc = cyc;
    end
    stalled   = m_valid && !m_ready;
    hold_data = m_data;
    hold_last = m_last;
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      tick();
      n++;
    end
    if (frames_seen < target) check("wait_frames", 32'(frames_seen), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_last"}, 32'(m_last), 32'd0);
    check({tag, "_m_data"}, m_data, 32'd0);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    check({tag, "_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_frame_cnt"}, frame_cnt, 32'd0);
  endtask

  initial begin
    int first_wr, acc_cnt, n, quiet;
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = 32'h0; m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Full frame of 1..256 with the sink always ready
    for (int i = 1; i <= 256; i++) begin
      s_valid = 1'b1; s_data = 32'(i);
      tick();
    end
    s_valid = 1'b0;
    wait_frames(1, 400);
    check("full_head", last_head, 32'hA55A0000);
    check("full_len", last_len, 32'h00000100);
    check("full_tail", last_tail, 32'h00000100);
    check("full_latency", 32'(head_cyc - last_wr_cyc), 32'd2);
    check("full_no_bubbles", 32'(frame_cycles), 32'd259);
    check("full_frame_cnt", frame_cnt, 32'd1);

    // Partial frame forced by the idle timeout
    tick();
    s_valid = 1'b1; s_data = 32'h11; tick(); first_wr = last_wr_cyc;
    s_data = 32'h22; tick();
    s_data = 32'h44; tick();
    s_valid = 1'b0;
    wait_frames(2, TIMEOUT + 100);
    check("to_latency", 32'(head_cyc - first_wr), 32'(TIMEOUT + 2));
    check("to_head", last_head, 32'hA55A0001);
    check("to_len", last_len, 32'd3);
    check("to_tail", last_tail, 32'h77);

    // Flush with nothing buffered produces nothing; then a one-word flush frame
    flush = 1'b1; tick(); flush = 1'b0;
    quiet = 0;
    for (int i = 0; i < 30; i++) begin
      if (m_valid) quiet++;
      tick();
    end
    check("flush_empty_quiet", 32'(quiet), 32'd0);
    check("flush_empty_cnt", frame_cnt, 32'd2);
    s_valid = 1'b1; s_data = 32'h0000DEAD; tick(); s_valid = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1; tick(); flush = 1'b0;
    wait_frames(3, 50);
    check("flush_len", last_len, 32'd1);
    check("flush_tail", last_tail, 32'h0000DEAD);

    // Back-pressure until the FIFO fills, then drain two full frames
    m_ready = 1'b0; acc_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      s_valid = 1'b1; s_data = 32'h10000000 + 32'(acc_cnt);
      tick();
      if (s_hs) acc_cnt++;
    end
    s_valid = 1'b0;
    check("bp_accepted", 32'(acc_cnt), 32'(FIFO_DEPTH));
    check("bp_level", 32'(fifo_level), 32'(FIFO_DEPTH));
    check("bp_s_ready", 32'(s_ready), 32'd0);
    check("bp_head_waiting", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    wait_frames(5, 1200);
    tick();
    check("bp_len", last_len, 32'd256);
    check("bp_drained", 32'(fifo_level), 32'd0);
    check("bp_cnt", frame_cnt, 32'd5);

    // Random traffic, random back-pressure and random flushes
    for (int i = 0; i < 4000; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = $urandom;
      m_ready = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 63) == 0);
      tick();
    end
    s_valid = 1'b0; m_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 0;
    while (!(sb.size() == 0 && beat == 0 && !m_valid) && n < 3000) begin
      tick();
      n++;
    end
    check("rand_drained", 32'(sb.size()), 32'd0);
    check("rand_frame_cnt", frame_cnt, 32'(frames_seen));

    // Reset in the middle of a payload
    for (int i = 0; i < 256; i++) begin
      s_valid = 1'b1; s_data = 32'hC0000000 + 32'(i);
      tick();
    end
    s_valid = 1'b0;
    n = 0;
    while (!(beat == 2 && pay_left <= cur_n - 4) && n < 100) begin
      tick();
      n++;
    end
    check("mid_in_payload", 32'(beat), 32'd2);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    s_valid = 1'b1; s_data = 32'h0000BEEF; tick();
    s_data = 32'h00001234; tick();
    s_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
    wait_frames(1, 50);
    check("post_rst_head", last_head, 32'hA55A0000);
    check("post_rst_len", last_len, 32'd2);
    check("post_rst_tail", last_tail, 32'h0000BEEF ^ 32'h00001234);
    check("post_rst_cnt", frame_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_framer.md
# stream_framer

Packs the merged 32-bit hit stream from the channel memory stage into self-describing frames for the host link. Sits directly downstream of the channel memory/multiplexer stage and consumes its valid/ready word stream. Words are absorbed into an internal FIFO, and each frame is emitted on an AXI-stream-style output with header, length, payload and XOR checksum. A frame is launched on a full frame, a timeout or an explicit flush.

## Interface
- DATA_WIDTH, 32, word width; fixed at 32, since the header and length packing depend on it.
- FRAME_WORDS, 256, maximum payload words per frame (1..65535).
- FIFO_DEPTH, 512, input FIFO depth in words, power of two, ≥ FRAME_WORDS.
- TIMEOUT, 1024, idle cycles with a non-empty FIFO before a partial frame is forced (≥ 2).
- FRAME_HEAD, 16'hA55A, frame marker placed in header bits [31:16].

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  single-cycle request to frame whatever is buffered.
- s_valid  in  1  input word valid (from memory stage m_valid).
- s_ready  out  1  input ready; equals !fifo_full.
- s_data  in  DATA_WIDTH  input word (from memory stage m_data).
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  output word.
- m_last  out  1  high on the checksum word, the last word of a frame.
- frame_cnt  out  32  frames completed; wraps.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO write: when s_valid && s_ready. FIFO read: only in PAYLOAD, on an output handshake. A simultaneous write and read leaves the level unchanged.
- Frame format, one word per beat:
  - HEAD = {FRAME_HEAD, seq[15:0]}.
  - LEN = {16'h0, n}.
  - n payload words in FIFO order.
  - TAIL = XOR of the n payload words, with m_last=1.
- seq starts at 0 and increments by 1 after each TAIL handshake, wrapping 16'hFFFF→0.
- FSM states: IDLE, HEAD, LEN, PAYLOAD, TAIL.
  - IDLE→HEAD when fifo_level ≥ FRAME_WORDS, or timeout fires, or flush_pend is set with fifo_level > 0.
  - On that transition, capture n = min(fifo_level, FRAME_WORDS).
  - HEAD→LEN, LEN→PAYLOAD and TAIL→IDLE each advance on an output handshake.
  - PAYLOAD→TAIL on the handshake of the n-th payload word.
- flush_pend:
  - Set by flush. Cleared on IDLE→HEAD.
  - Cleared in IDLE when fifo_level == 0, so empty frames are never produced.
  - A flush during an active frame stays pending and is evaluated on return to IDLE.
- Timeout counter:
  - Counts only in IDLE with fifo_level > 0; held at 0 otherwise.
  - Fires when it reaches TIMEOUT-1. Cleared on frame start.
- Checksum: the accumulator is cleared at HEAD, and XORs each payload word on its handshake.
- frame_cnt increments on each TAIL handshake.
- Words arriving during a frame are buffered and belong to later frames. n is not re-evaluated mid-frame.

## Timing
- Reset values:
  - State = IDLE.
  - m_valid=0, m_last=0, m_data=0.
  - s_ready=1, fifo_level=0, frame_cnt=0.
  - seq=0, flush_pend=0, timeout counter=0.
- Reset mid-frame aborts the frame immediately and discards FIFO contents.
- All outputs are registered. While m_valid=1 && m_ready=0, m_data and m_last hold stable, and m_valid stays high until the handshake.
- Latency:
  - A word written at cycle t is counted in fifo_level at t+1.
  - The trigger is evaluated in IDLE at t+1, and HEAD appears on m_valid at t+2.
- With m_ready held high, a frame of n payload words occupies exactly n+3 consecutive cycles with no bubbles.
- A new frame may start the cycle after the TAIL handshake, so there is 1 idle cycle minimum between frames.
- Full FIFO: s_ready=0. A read in the same cycle does not raise s_ready until the next cycle.
- Timeout with the FIFO never refilled: HEAD appears TIMEOUT+1 cycles after the first word is counted.

## Test plan
- Reset, then 256 words 0x00000001..0x00000100 with m_ready=1 → frame HEAD=0xA55A0000, LEN=0x00000100, payload in order, TAIL=0x00000100 with m_last=1; frame_cnt=1.
- 3 words 0x11, 0x22, 0x44, then idle → after TIMEOUT+1 cycles, frame with LEN=3 and TAIL=0x77; seq of the next frame = 1.
- flush with an empty FIFO → no output. Then 1 word 0xDEAD, then flush → frame with LEN=1 and TAIL=0x0000DEAD.
- m_ready held low while 600 words are offered → s_ready drops at fifo_level=512. Release → two 256-word frames, and the words are lossless and ordered.
- Random m_ready toggling during a frame → m_data and m_last stable while stalled; checksum correct.
- Assert reset mid-PAYLOAD → all outputs return to their reset values within the same cycle, and the next frame has seq=0.
